burst_mem_responder: RTL and testbench

//   Synthesizable responder for the 64-bit, 4-beat physical-memory burst interface driven by mp4
//   (pmem_read/pmem_write/pmem_address/pmem_wdata -> pmem_rdata/pmem_resp).

---
 rtl/burst_mem_responder.sv | 143 ++++++++++++++
 tb/tb_burst_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-organised backing store answering 4-beat, 64-bit
// physical-memory bursts after a fixed access latency.
module burst_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BEATS       = 4,
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [DATA_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int IDX_W     = $clog2(DEPTH_LINES);
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MEM_W     = IDX_W + BEAT_W;
  localparam int MEM_DEPTH = 1 << MEM_W;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t                state_reg;
  logic                  op_write_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [LAT_W-1:0]      lat_cnt_reg;
  logic [BEAT_W-1:0]     beat_cnt_reg;

  // One word per beat; a line occupies BEATS consecutive words.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  req_held;
  logic                  last_beat;
  logic                  mem_we;
  logic                  rd_en;
  logic [MEM_W-1:0]      rd_addr;
  logic [IDX_W-1:0]      req_idx;
  logic                  unused_addr;

  // Offset bits and the aliasing upper bits do not select anything.
  assign unused_addr = ^{pmem_address[4:0], pmem_address[ADDR_WIDTH-1:5+IDX_W]};

  assign req_idx   = pmem_address[5 +: IDX_W];
  // Only the request line of the accepted operation has to stay high.
  assign req_held  = op_write_reg ? pmem_write : pmem_read;
  assign last_beat = (beat_cnt_reg == BEAT_W'(BEATS - 1));
  assign mem_we    = (state_reg == BURST) && op_write_reg && req_held;
  // Read data is fetched one edge ahead so it appears together with resp.
  assign rd_en     = !op_write_reg && req_held &&
                     (((state_reg == WAIT) && (lat_cnt_reg == '0)) ||
                      ((state_reg == BURST) && !last_beat));

  // Next beat to fetch: beat 0 when leaving WAIT, otherwise the following beat.
  always_comb begin
    rd_addr = {idx_reg, BEAT_W'(0)};
    if (state_reg == BURST) begin
      rd_addr = {idx_reg, beat_cnt_reg + BEAT_W'(1)};
    end
  end

  // Backing store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{idx_reg, beat_cnt_reg}] <= pmem_wdata;
    end
  end

  // Burst sequencer with registered handshake, status and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      lat_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      pmem_resp    <= 1'b0;
      pmem_rdata   <= '0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= 1'b0;
      if (rd_en) begin
        pmem_rdata <= mem[rd_addr];
      end
      case (state_reg)
        IDLE: begin
          if (pmem_read && pmem_write) begin
            protocol_err <= 1'b1;
          end else if (pmem_read || pmem_write) begin
            op_write_reg <= pmem_write;
            idx_reg      <= req_idx;
            lat_cnt_reg  <= LAT_W'(LATENCY - 1);
            state_reg    <= WAIT;
            busy         <= 1'b1;
          end
        end
        WAIT: begin
          if (!req_held) begin
            protocol_err <= 1'b1;
            state_reg    <= IDLE;
            busy         <= 1'b0;
          end else if (lat_cnt_reg == '0) begin
            beat_cnt_reg <= '0;
            pmem_resp    <= 1'b1;
            state_reg    <= BURST;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        BURST: begin
          if (!req_held) begin
            protocol_err <= 1'b1;
            pmem_resp    <= 1'b0;
            state_reg    <= IDLE;
            busy         <= 1'b0;
          end else if (last_beat) begin
            pmem_resp <= 1'b0;
            state_reg <= DONE;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
          end
        end
        DONE: begin
          // Request may still be high here; it is only considered from IDLE.
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: write/read, aliasing, protocol
// errors, reset mid-burst and back-to-back reads.
module tb_burst_mem_responder;

  localparam int LAT = 8;
  localparam int NB  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_address = '0;
  logic [63:0] pmem_wdata = '0;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        busy;
  logic        protocol_err;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [255:0] line_a;
  logic [255:0] line_b;

  burst_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  // Full read burst; lat counts cycles from acceptance edge to first resp.
  task automatic read_burst(input logic [31:0] addr, output logic [255:0] line,
                            output int lat, output bit ok);
    @(negedge clk);
    pmem_address = addr;
    pmem_read    = 1'b1;
    pmem_write   = 1'b0;
    ok = 1'b0; lat = -1; line = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pmem_resp) begin lat = i; break; end
    end
    if (lat >= 0) begin
      ok = 1'b1;
      line[63:0] = pmem_rdata;
      for (int b = 1; b < NB; b++) begin
        @(negedge clk);
        if (!pmem_resp) ok = 1'b0;
        line[b*64 +: 64] = pmem_rdata;
      end
      @(negedge clk);
      if (pmem_resp) ok = 1'b0;
    end
    pmem_read = 1'b0;
    $display("read  addr=%h line=%h lat=%0d ok=%0d", addr, line, lat, ok);
  endtask

  // Full write burst; wdata for beat k is presented while beat k is answered.
  task automatic write_burst(input logic [31:0] addr, input logic [255:0] line,
                             output bit ok);
    int k;
    @(negedge clk);
    pmem_address = addr;
    pmem_write   = 1'b1;
    pmem_read    = 1'b0;
    pmem_wdata   = line[63:0];
    ok = 1'b0; k = 0;
    for (int i = 0; i < 60 && k < NB; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_wdata = line[k*64 +: 64];
        k++;
      end
    end
    if (k == NB) begin
      @(negedge clk);
      ok = !pmem_resp;
    end
    pmem_write = 1'b0;
    $display("write addr=%h line=%h beats=%0d ok=%0d", addr, line, k, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (pmem_resp !== 1'b0) $display("FAIL reset_resp: got %b expected 0", pmem_resp); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (protocol_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", protocol_err); else pass_cnt++;
    check_cnt++; if (pmem_rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", pmem_rdata); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else pass_cnt++;
    $display("reset done");
  endtask

  task automatic test_write_read();
    bit ok; int lat; logic [255:0] rd;
    write_burst(32'h0000_0040, line_a, ok);
    check_cnt++; if (ok !== 1'b1) $display("FAIL wr_handshake: got %b expected 1", ok); else pass_cnt++;
    read_burst(32'h0000_0040, rd, lat, ok);
    check_cnt++; if (ok !== 1'b1) $display("FAIL rd_handshake: got %b expected 1", ok); else pass_cnt++;
    check_cnt++; if (rd !== line_a) $display("FAIL rd_data: got %h expected %h", rd, line_a); else pass_cnt++;
    check_cnt++; if (lat != LAT) $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); else pass_cnt++;
  endtask

  task automatic test_alias();
    bit ok; int lat; logic [255:0] rd;
    read_burst(32'h0000_005F, rd, lat, ok);
    check_cnt++; if (rd !== line_a) $display("FAIL alias_offset: got %h expected %h", rd, line_a); else pass_cnt++;
    read_burst(32'h0000_8040, rd, lat, ok);
    check_cnt++; if (rd !== line_a) $display("FAIL alias_upper: got %h expected %h", rd, line_a); else pass_cnt++;
  endtask

  task automatic test_both_high();
    bit ok; int lat; logic [255:0] rd;
    @(negedge clk);
    pmem_address = 32'h0000_0040;
    pmem_wdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    pmem_read    = 1'b1;
    pmem_write   = 1'b1;
    @(negedge clk);
    check_cnt++; if (protocol_err !== 1'b1) $display("FAIL both_err: got %b expected 1", protocol_err); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL both_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (pmem_resp !== 1'b0) $display("FAIL both_resp: got %b expected 0", pmem_resp); else pass_cnt++;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
    check_cnt++; if (protocol_err !== 1'b0) $display("FAIL both_err_pulse: got %b expected 0", protocol_err); else pass_cnt++;
    $display("read+write together flagged");
    read_burst(32'h0000_0040, rd, lat, ok);
    check_cnt++; if (rd !== line_a) $display("FAIL both_mem_kept: got %h expected %h", rd, line_a); else pass_cnt++;
  endtask

  task automatic test_read_drop();
    bit ok; int lat; int k; logic [127:0] seen;
    logic [255:0] rd;
    @(negedge clk);
    pmem_address = 32'h0000_0040;
    pmem_read    = 1'b1;
    k = 0; seen = '0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        if (k < 2) seen[k*64 +: 64] = pmem_rdata;
        if (k == 2) pmem_read = 1'b0;
        k++;
      end
    end
    pmem_read = 1'b0;
    check_cnt++; if (seen !== line_a[127:0]) $display("FAIL drop_beats01: got %h expected %h", seen, line_a[127:0]); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (protocol_err !== 1'b1) $display("FAIL drop_err: got %b expected 1", protocol_err); else pass_cnt++;
    check_cnt++; if (pmem_resp !== 1'b0) $display("FAIL drop_resp: got %b expected 0", pmem_resp); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (protocol_err !== 1'b0) $display("FAIL drop_err_pulse: got %b expected 0", protocol_err); else pass_cnt++;
    $display("read dropped at beat 2");
    read_burst(32'h0000_0040, rd, lat, ok);
    check_cnt++; if (rd !== line_a) $display("FAIL drop_reread: got %h expected %h", rd, line_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    bit ok; int lat; bit got0;
    logic [255:0] rd;
    logic [255:0] expect_line;
    @(negedge clk);
    pmem_address = 32'h0000_0040;
    pmem_write   = 1'b1;
    pmem_wdata   = line_b[63:0];
    got0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pmem_resp) begin got0 = 1'b1; break; end
    end
    @(negedge clk);
    check_cnt++; if (pmem_resp !== got0) $display("FAIL rstw_beat1_resp: got %b expected 1", pmem_resp); else pass_cnt++;
    pmem_wdata = line_b[127:64];
    rst = 1'b1;
    #1;
    check_cnt++; if (pmem_resp !== 1'b0) $display("FAIL rstw_resp: got %b expected 0", pmem_resp); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rstw_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (pmem_rdata !== 64'h0) $display("FAIL rstw_rdata: got %h expected 0", pmem_rdata); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    pmem_write = 1'b0;
    $display("reset during write beat 1");
    expect_line = {line_a[255:64], line_b[63:0]};
    read_burst(32'h0000_0040, rd, lat, ok);
    check_cnt++; if (rd !== expect_line) $display("FAIL rstw_partial: got %h expected %h", rd, expect_line); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [26:0] resp_trace;
    logic [26:0] busy_trace;
    logic [26:0] resp_exp;
    logic [26:0] busy_exp;
    logic [255:0] second;
    bit err_seen;
    int k;
    // Burst 1 answers at 8..11, DONE 12, IDLE 13, burst 2 answers at 22..25.
    resp_exp = '0;
    busy_exp = '1;
    for (int i = LAT; i < LAT + NB; i++) resp_exp[i] = 1'b1;
    for (int i = 2*LAT + NB + 2; i < 2*LAT + 2*NB + 2; i++) resp_exp[i] = 1'b1;
    busy_exp[LAT + NB + 1] = 1'b0;
    @(negedge clk);
    pmem_address = 32'h0000_0040;
    pmem_read    = 1'b1;
    err_seen = 1'b0; k = 0; second = '0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      resp_trace[i] = pmem_resp;
      busy_trace[i] = busy;
      if (protocol_err) err_seen = 1'b1;
      if (pmem_resp && i > LAT + NB + 1 && k < NB) begin
        second[k*64 +: 64] = pmem_rdata;
        k++;
      end
    end
    pmem_read = 1'b0;
    check_cnt++; if (resp_trace !== resp_exp) $display("FAIL b2b_resp: got %b expected %b", resp_trace, resp_exp); else pass_cnt++;
    check_cnt++; if (busy_trace !== busy_exp) $display("FAIL b2b_busy: got %b expected %b", busy_trace, busy_exp); else pass_cnt++;
    check_cnt++; if (second !== line_a) $display("FAIL b2b_data: got %h expected %h", second, line_a); else pass_cnt++;
    check_cnt++; if (err_seen !== 1'b0) $display("FAIL b2b_err: got %b expected 0", err_seen); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL b2b_end_busy: got %b expected 0", busy); else pass_cnt++;
    $display("back-to-back reads resp=%b busy=%b", resp_trace, busy_trace);
  endtask

  initial begin
    line_a = {64'hA3A3_0000_1111_0003, 64'hA2A2_0000_1111_0002,
              64'hA1A1_0000_1111_0001, 64'hA0A0_0000_1111_0000};
    line_b = {64'hB3B3_5555_2222_0003, 64'hB2B2_5555_2222_0002,
              64'hB1B1_5555_2222_0001, 64'hB0B0_5555_2222_0000};
    test_reset();
    test_write_read();
    test_alias();
    test_both_high();
    test_read_drop();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
